// File: rtl/eth_frame_detector_mem_port.sv
// Pattern-RAM port arbiter: shares one single-port RAM between the AXI register
// requester (req/we/ack) and the detector core's fetch port, core first.
module eth_frame_detector_mem_port #(
  parameter int C_AXI_WIDTH   = 32,
  parameter int C_ADDR_WIDTH  = 11,
  parameter int C_RAM_LATENCY = 2,
  parameter int C_STALL_LIMIT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_req,
  input  logic                    s_we,
  output logic                    s_ack,
  input  logic [C_ADDR_WIDTH-1:0] s_addr,
  input  logic [C_AXI_WIDTH-1:0]  s_wdata,
  output logic [C_AXI_WIDTH-1:0]  s_rdata,
  input  logic                    core_req,
  input  logic [C_ADDR_WIDTH-1:0] core_addr,
  output logic                    core_grant,
  output logic [C_AXI_WIDTH-1:0]  core_rdata,
  output logic                    core_stalled,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [C_ADDR_WIDTH-1:0] ram_addr,
  output logic [C_AXI_WIDTH-1:0]  ram_wdata,
  input  logic [C_AXI_WIDTH-1:0]  ram_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic [1:0] LAT_INIT  = 2'(C_RAM_LATENCY - 1);
  localparam logic [7:0] STALL_MAX = 8'(C_STALL_LIMIT);

  state_e                   state_q, state_d;
  logic [1:0]               lat_q, lat_d;
  logic [7:0]               stall_q, stall_d;
  logic                     s_ack_q, s_ack_d;
  logic [C_AXI_WIDTH-1:0]   s_rdata_q, s_rdata_d;
  logic                     core_stalled_q, core_stalled_d;

  // Arbitration, RAM drive and next-state; the AXI slot only ever issues from IDLE.
  always_comb begin
    state_d        = state_q;
    lat_d          = lat_q;
    stall_d        = stall_q;
    s_ack_d        = 1'b0;
    s_rdata_d      = s_rdata_q;
    core_stalled_d = 1'b0;
    core_grant     = core_req;
    ram_en         = core_req;
    ram_we         = 1'b0;
    ram_addr       = core_addr;
    ram_wdata      = {C_AXI_WIDTH{1'b0}};
    case (state_q)
      IDLE: begin
        if (s_req && (!core_req || (stall_q == STALL_MAX))) begin
          core_grant     = 1'b0;
          ram_en         = 1'b1;
          ram_we         = s_we;
          ram_addr       = s_addr;
          ram_wdata      = s_wdata;
          core_stalled_d = core_req;
          stall_d        = 8'd0;
          if (s_we) begin
            state_d = ACK;
            s_ack_d = 1'b1;
          end else begin
            state_d = RD_WAIT;
            lat_d   = LAT_INIT;
          end
        end else if (s_req && (stall_q != STALL_MAX)) begin
          stall_d = stall_q + 8'd1;
        end else begin
          stall_d = stall_q;
        end
      end
      RD_WAIT: begin
        // Sampling point is fixed by the AXI slot's own latency, so core returns never land here.
        if (lat_q == 2'd0) begin
          s_rdata_d = ram_rdata;
          s_ack_d   = 1'b1;
          state_d   = ACK;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      ACK: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!s_req) begin
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight read without an ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      lat_q          <= 2'd0;
      stall_q        <= 8'd0;
      s_ack_q        <= 1'b0;
      s_rdata_q      <= {C_AXI_WIDTH{1'b0}};
      core_stalled_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lat_q          <= lat_d;
      stall_q        <= stall_d;
      s_ack_q        <= s_ack_d;
      s_rdata_q      <= s_rdata_d;
      core_stalled_q <= core_stalled_d;
    end
  end

  assign s_ack        = s_ack_q;
  assign s_rdata      = s_rdata_q;
  assign core_stalled = core_stalled_q;
  assign core_rdata   = ram_rdata;

endmodule
